// File: rtl/instr_mem_loader.sv
// Streams little-endian bytes into instruction words and writes them through the
// instruction memory debug port, holding the core in reset until the program is loaded.
module instr_mem_loader #(
    parameter int XLEN                   = 64,
    parameter int INSTRUCTION_LENGTH     = XLEN / 2,
    parameter int SIMULATION_MEMORY_SIZE = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [SIMULATION_MEMORY_SIZE-1:0] prog_len,
    input  logic                              byte_valid,
    input  logic [7:0]                        byte_data,
    output logic                              byte_ready,
    output logic                              dbg_wr_en,
    output logic [SIMULATION_MEMORY_SIZE-1:0] dbg_addr,
    output logic [INSTRUCTION_LENGTH-1:0]     dbg_instr,
    output logic                              cpu_hold,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [SIMULATION_MEMORY_SIZE-1:0] words_written
);
    localparam int AW    = SIMULATION_MEMORY_SIZE;
    localparam int IL    = INSTRUCTION_LENGTH;
    localparam int BPW   = IL / 8;
    localparam int DEPTH = 2 ** (AW - 1);
    localparam int IW    = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [AW-1:0] DEPTH_V  = AW'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] words_q;
    logic [AW-1:0] addr_q;
    logic [IW-1:0] idx_q;
    logic [IL-1:0] instr_q;
    logic          ready_q;
    logic          wr_en_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic          hold_q;
    logic [AW-1:0] words_inc;

    assign words_inc = words_q + AW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            words_q <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            instr_q <= '0;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        hold_q  <= 1'b1;
                        words_q <= '0;
                        if (prog_len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else if (prog_len > DEPTH_V) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= S_RECV;
                            len_q   <= prog_len;
                            addr_q  <= '0;
                            idx_q   <= '0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (byte_valid && ready_q) begin
                        for (int k = 0; k < BPW; k++) begin
                            if (idx_q == IW'(k)) instr_q[8*k +: 8] <= byte_data;
                        end
                        // Drop ready with the last byte so the write cycle sees a stable word.
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_WRITE;
                            ready_q <= 1'b0;
                            wr_en_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    wr_en_q <= 1'b0;
                    words_q <= words_inc;
                    idx_q   <= '0;
                    if (words_inc == len_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                    end else begin
                        state_q <= S_RECV;
                        addr_q  <= addr_q + AW'(1);
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_ready    = ready_q;
    assign dbg_wr_en     = wr_en_q;
    assign dbg_addr      = addr_q;
    assign dbg_instr     = instr_q;
    assign cpu_hold      = hold_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_q;

endmodule
